// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, BCD limits and parameter defaults for the stopwatch.
package stopwatch_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } state_t;
    localparam int CS_MAX          = 99;
    localparam int SEC_MAX         = 59;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int MAX_MIN_DEF     = 59;
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter 00..MAX with same-cycle carry out for chaining.
module bcd_mod_counter #(
    parameter int MAX = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] count,
    output logic       carry
);
    localparam logic [7:0] MAX_BCD = 8'(((MAX / 10) << 4) | (MAX % 10));
    logic [7:0] w_next;
    assign carry  = en && (count == MAX_BCD);
    assign w_next = carry ? 8'h00
                  : (count[3:0] == 4'd9) ? {count[7:4] + 4'd1, 4'd0}
                  : {count[7:4], count[3:0] + 4'd1};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= 8'h00;
        else if (clr)
            count <= 8'h00;
        else if (en)
            count <= w_next;
    end
endmodule

// File: rtl/stopwatch_control.sv
// stopwatch_control: run/pause/clear sequencer and BCD mm:ss.cc timekeeper driven by a sampled 100 Hz tick.
// Optional lap-hold display freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_control
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int MAX_MIN     = MAX_MIN_DEF
) (
    input  logic       CLK_50_MHz,
    input  logic       reset_n,
    input  logic       CLK_100Hz,
    input  logic       start_stop_btn,
    input  logic       clear_btn,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       wrap_pulse
);
    logic [1:0] r_rst_sync;
    logic       w_rst_n;
    always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
        if (!reset_n)
            r_rst_sync <= 2'b00;
        else
            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Lane 0 = tick, 1 = start, 2 = clear. Events are gated until the pipeline holds
    // only post-reset samples, so a level already high at release is not an edge.
    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [2:0]                  r_prev;
    logic [SYNC_STAGES:0]        r_vld;
    logic [2:0]                  w_ev;
    logic                        w_tick, w_start, w_clr;
    always_ff @(posedge CLK_50_MHz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync <= '0;
            r_prev <= '0;
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], {clear_btn, start_stop_btn, CLK_100Hz}};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
        end
    end
    assign w_ev = r_vld[SYNC_STAGES] ? (r_sync[SYNC_STAGES-1] & ~r_prev) : 3'b000;
    assign {w_clr, w_start, w_tick} = w_ev;

    state_t r_state, w_next_state;
    logic   r_running, r_wrap;
    logic   w_cnt_en, w_cnt_clr;
    always_ff @(posedge CLK_50_MHz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_running <= (w_next_state == RUNNING);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_start ? RUNNING : IDLE;
            RUNNING: w_next_state = w_start ? PAUSED : RUNNING;
            PAUSED:  w_next_state = w_clr ? IDLE : w_start ? RUNNING : PAUSED;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_cnt_en  = (r_state == RUNNING) && w_tick;
        w_cnt_clr = (r_state == PAUSED) && w_clr;
    end

    logic [7:0] w_cs, w_sec, w_min;
    logic       w_cs_c, w_sec_c, w_min_c;
    bcd_mod_counter #(.MAX(CS_MAX)) u_cs (
        .clk(CLK_50_MHz), .rst_n(w_rst_n), .en(w_cnt_en), .clr(w_cnt_clr),
        .count(w_cs), .carry(w_cs_c)
    );
    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk(CLK_50_MHz), .rst_n(w_rst_n), .en(w_cs_c), .clr(w_cnt_clr),
        .count(w_sec), .carry(w_sec_c)
    );
    bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
        .clk(CLK_50_MHz), .rst_n(w_rst_n), .en(w_sec_c), .clr(w_cnt_clr),
        .count(w_min), .carry(w_min_c)
    );

    always_ff @(posedge CLK_50_MHz or negedge w_rst_n) begin
        if (!w_rst_n)
            r_wrap <= 1'b0;
        else
            r_wrap <= w_min_c;
    end
    assign running    = r_running;
    assign wrap_pulse = r_wrap;

`ifdef STOPWATCH_LAP_EN
    // Clear while running toggles a display freeze; counting carries on underneath.
    logic        r_lap_hold;
    logic [23:0] r_lap;
    logic        w_lap_tgl;
    assign w_lap_tgl = (r_state == RUNNING) && w_clr && !w_start;
    always_ff @(posedge CLK_50_MHz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_lap_hold <= 1'b0;
            r_lap      <= '0;
        end else begin
            r_lap_hold <= (w_next_state == RUNNING) && (r_lap_hold ^ w_lap_tgl);
            if (w_lap_tgl && !r_lap_hold)
                r_lap <= {w_min, w_sec, w_cs};
        end
    end
    assign {min_bcd, sec_bcd, cs_bcd} = r_lap_hold ? r_lap : {w_min, w_sec, w_cs};
`else
    assign {min_bcd, sec_bcd, cs_bcd} = {w_min, w_sec, w_cs};
`endif
endmodule

// File: doc/stopwatch_control.md
Name: stopwatch_control

Overview:
- Run-control and timekeeping sequencer for the stopwatch.
- Samples the 100 Hz output of the clock divider in the 50 MHz domain and turns each rising edge into a one-cycle tick.
- Sequences IDLE/RUNNING/PAUSED from two pre-debounced push-buttons.
- Advances a BCD mm:ss.cc time value that feeds the display path.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers for CLK_100Hz and both buttons (legal 2..4).
- MAX_MIN, 59, highest minutes value before wrap (legal 1..99).

Ports:
- CLK_50_MHz  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- CLK_100Hz  input  1  divider output, treated as asynchronous data, never used as a clock.
- start_stop_btn  input  1  debounced level, active-high; a rising edge toggles run/pause.
- clear_btn  input  1  debounced level, active-high; a rising edge clears.
- cs_bcd  output  8  centiseconds, two BCD digits.
- sec_bcd  output  8  seconds, two BCD digits.
- min_bcd  output  8  minutes, two BCD digits.
- running  output  1  high in RUNNING.
- wrap_pulse  output  1  one-cycle pulse on rollover MAX_MIN:59.99 -> 00:00.00.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - state = IDLE.
  - All BCD outputs = 8'h00.
  - running = 0, wrap_pulse = 0.
  - Synchroniser and edge-detect flops = 0.
- Input conditioning: each async input passes through SYNC_STAGES flops, then a one-flop rising-edge detector.
  - Tick, start and clear events are one clock wide.
  - Latency from an input edge to the registered output change is SYNC_STAGES+1 clocks.
- States:
  - IDLE: counters = 0. Start event -> RUNNING. Clear event -> stay in IDLE, no change.
  - RUNNING: each tick increments the time. Start event -> PAUSED. Clear event is ignored while running.
  - PAUSED: counters hold. Start event -> RUNNING, resuming from the held value. Clear event -> IDLE with all counters zeroed.
- Simultaneous events in the same clock:
  - Tick plus start in RUNNING: the increment is applied, then the state moves to PAUSED.
  - Start plus clear in PAUSED: clear wins, next state is IDLE.
  - Start plus clear in IDLE: start wins, next state is RUNNING.
  - Start plus clear in RUNNING: start wins, next state is PAUSED.
- Counting (BCD, each digit stays within 0..9):
  - cs: 00..99.
  - sec: 00..59.
  - min: 00..MAX_MIN.
  - Carry ripples within the same cycle as the tick.
  - At MAX_MIN:59.99, a tick sets the time to 00:00.00, asserts wrap_pulse for exactly that cycle, and the block stays in RUNNING.
- No tick is lost or double-counted, whatever the phase of CLK_100Hz relative to button edges.
- A reset assertion mid-run returns to IDLE/zero immediately. After deassertion, the first tick is recognised only on a fresh CLK_100Hz rising edge.
- running is registered and changes in the same cycle as the state register.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- When defined:
  - A clear event in RUNNING toggles a lap-hold flag instead of being ignored.
  - While lap-hold is set, cs_bcd/sec_bcd/min_bcd show the value frozen at the clear event. Internal counting continues.
  - A second clear event in RUNNING releases the hold, and the outputs show live time on the next clock.
  - Entering PAUSED or IDLE releases the hold.
  - Start plus clear in the same cycle in RUNNING: start wins, giving PAUSED with the hold released.
- When not defined: clear in RUNNING is ignored, no lap registers are built, and the outputs are always the live counters.

Decomposition:
- Package stopwatch_pkg holds:
  - The state type with encodings IDLE = 2'b00, RUNNING = 2'b01, PAUSED = 2'b10.
  - Constants CS_MAX = 99 and SEC_MAX = 59.
  - Default values for SYNC_STAGES and MAX_MIN.
- One natural sub-module, bcd_mod_counter: a two-digit BCD counter with parameter MAX, inputs en and clr, outputs count and carry. It is instantiated three times and chained by carry.
- Synchroniser plus edge detector stays inline.

Test Plan:
- Reset, then start edge, then 150 CLK_100Hz edges -> running = 1, time 00:01.50. No increment appears earlier than SYNC_STAGES+1 clocks after each edge.
- Running at 00:00.37, start edge -> PAUSED, running = 0. Further 10 ticks leave the value at 00:00.37. Start edge -> ticks resume, next tick gives 00:00.38.
- PAUSED at 00:12.34, start and clear asserted in the same cycle -> IDLE, all outputs 8'h00, running = 0.
- Preload via ticks to 59:59.99, one more tick -> 00:00.00, one-cycle wrap_pulse, state RUNNING. Also with MAX_MIN = 1: the tick after 01:59.99 wraps.
- reset_n pulsed low for 100 ns during RUNNING at 00:05.00 -> outputs zero asynchronously, IDLE after release, no spurious tick counted.
- With STOPWATCH_LAP_EN defined: clear at 00:03.21 while running -> outputs hold 00:03.21 for 100 ticks. Second clear -> outputs show 00:04.21.
